// File: rtl/cp0_pkg.sv
// cp0_pkg: CP0 register numbers, field positions,
// exception codes and default vectors for mem_exception.
package cp0_pkg;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_TLBL = 5'd2,
    EXC_TLBS = 5'd3,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_SYS  = 5'd8,
    EXC_RI   = 5'd10,
    EXC_CPU  = 5'd11
  } exc_code_t;

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;

  localparam int ST_IE  = 0;
  localparam int ST_EXL = 1;
  localparam int ST_UM  = 4;
  localparam int ST_IM  = 8;
  localparam int CA_IP  = 8;

  localparam logic [31:0] DEF_EXC_VECTOR    = 32'h8000_0180;
  localparam logic [31:0] DEF_REFILL_VECTOR = 32'h8000_0000;

  function automatic logic is_tlb(exc_code_t c);
    return (c == EXC_TLBL) || (c == EXC_TLBS);
  endfunction

  function automatic logic sets_badvaddr(exc_code_t c);
    return is_tlb(c) || (c == EXC_ADEL) || (c == EXC_ADES);
  endfunction

endpackage

// File: rtl/mem_exception_if.sv
// mem_exception_if: EX/MEM exception fields in, flush
// redirect back out to the pipeline registers.
interface mem_exception_if;

  logic        MemValidInstruction;
  logic        MemReservedInstruction;
  logic [31:0] MemPC;
  logic [31:0] MemBadAddress;
  logic        MemIsInDelaySlot;
  logic        Memsyscall;
  logic        Memeret;
  logic        Memprivilege;
  logic        TLBMissRead;
  logic        TLBMissWrite;
  logic        ReadError;
  logic        WriteError;
  logic        MemAddressReadPrivilege;
  logic        MemAddressWritePrivilege;
  logic        MemWriteCP;
  logic [4:0]  MemWriteCPAddress;
  logic [31:0] MemWriteCPData;
  logic        flush;
  logic [31:0] flushTarget;
  logic        ExceptionTaken;

  modport master (
    output MemValidInstruction, MemReservedInstruction,
    output MemPC, MemBadAddress, MemIsInDelaySlot,
    output Memsyscall, Memeret, Memprivilege,
    output TLBMissRead, TLBMissWrite,
    output ReadError, WriteError,
    output MemAddressReadPrivilege, MemAddressWritePrivilege,
    output MemWriteCP, MemWriteCPAddress, MemWriteCPData,
    input  flush, flushTarget, ExceptionTaken
  );

  modport slave (
    input  MemValidInstruction, MemReservedInstruction,
    input  MemPC, MemBadAddress, MemIsInDelaySlot,
    input  Memsyscall, Memeret, Memprivilege,
    input  TLBMissRead, TLBMissWrite,
    input  ReadError, WriteError,
    input  MemAddressReadPrivilege, MemAddressWritePrivilege,
    input  MemWriteCP, MemWriteCPAddress, MemWriteCPData,
    output flush, flushTarget, ExceptionTaken
  );

endinterface

// File: rtl/cp0_timer.sv
// cp0_timer: free-running Count, Compare and the
// sticky timer-pending flag feeding IP7.
module cp0_timer (
  input  logic        clock,
  input  logic        reset,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        pending
);

  logic [31:0] count_next;

  assign count_next = count_we ? wdata : count + 32'd1;

  // match on the new value so IP7 shows with Count==Compare
  always_ff @(posedge clock) begin
    if (!reset) begin
      count   <= '0;
      compare <= '0;
      pending <= 1'b0;
    end else begin
      count <= count_next;
      if (compare_we) begin
        compare <= wdata;
        pending <= 1'b0;
      end else if (count_next == compare) begin
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_exception.sv
// mem_exception: Mem-stage exception priority and CP0 commit.
// Timer (Count/Compare) built in with MEM_EXCEPTION_TIMER_EN.
module mem_exception
  import cp0_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR    = DEF_EXC_VECTOR,
  parameter logic [31:0] REFILL_VECTOR = DEF_REFILL_VECTOR
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           ready,
  mem_exception_if.slave mem,
  input  logic [5:0]     HardwareInt,
  input  logic [4:0]     CPReadAddress,
  output logic [31:0]    CPReadData,
  output logic           UserMode
);

  logic        st_ie;
  logic        st_exl;
  logic        st_um;
  logic [7:0]  st_im;
  logic        ca_bd;
  exc_code_t   ca_exc;
  logic [1:0]  ip_sw;
  logic [5:0]  ip_hw;
  logic [31:0] epc;
  logic [31:0] badvaddr;
  logic [31:0] count;
  logic [31:0] compare;
  logic        pending;
  logic [7:0]  ip;
  logic [31:0] status_w;
  logic [31:0] cause_w;
  logic        exc;
  logic        eret;
  logic        wr;
  exc_code_t   code;
  logic [31:0] target;
  logic [31:0] wdata;

  assign wdata    = mem.MemWriteCPData;
  assign UserMode = st_um & ~st_exl;
  assign ip       = {ip_hw[5] | pending, ip_hw[4:0], ip_sw};
  assign status_w = {16'b0, st_im, 3'b0, st_um,
                     2'b0, st_exl, st_ie};
  assign cause_w  = {ca_bd, 15'b0, ip, 1'b0, ca_exc, 2'b0};

  always_comb begin
    exc  = 1'b1;
    code = EXC_INT;
    if (!mem.MemValidInstruction)
      exc = 1'b0;
    else if (st_ie && !st_exl && |(ip & st_im))
      code = EXC_INT;
    else if (mem.TLBMissRead)
      code = EXC_TLBL;
    else if (mem.ReadError ||
             (mem.MemAddressReadPrivilege && UserMode))
      code = EXC_ADEL;
    else if (mem.MemReservedInstruction)
      code = EXC_RI;
    else if (mem.Memprivilege && UserMode)
      code = EXC_CPU;
    else if (mem.Memsyscall)
      code = EXC_SYS;
    else if (mem.TLBMissWrite)
      code = EXC_TLBS;
    else if (mem.WriteError ||
             (mem.MemAddressWritePrivilege && UserMode))
      code = EXC_ADES;
    else
      exc = 1'b0;
  end

  assign eret = mem.MemValidInstruction & mem.Memeret & ~exc;
  assign wr   = ready & mem.MemValidInstruction
              & mem.MemWriteCP & ~exc;

  always_comb begin
    target = '0;
    if (!reset)
      target = '0;
    else if (exc)
      target = (is_tlb(code) && !st_exl) ? REFILL_VECTOR
                                         : EXC_VECTOR;
    else if (eret)
      target = epc;
  end

  assign mem.flush          = reset & (exc | eret);
  assign mem.ExceptionTaken = reset & exc;
  assign mem.flushTarget    = target;

`ifdef MEM_EXCEPTION_TIMER_EN
  cp0_timer u_timer (
    .clock      (clock),
    .reset      (reset),
    .count_we   (wr && mem.MemWriteCPAddress == REG_COUNT),
    .compare_we (wr && mem.MemWriteCPAddress == REG_COMPARE),
    .wdata      (wdata),
    .count      (count),
    .compare    (compare),
    .pending    (pending)
  );
`else
  assign count   = '0;
  assign compare = '0;
  assign pending = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      st_ie    <= 1'b0;
      st_exl   <= 1'b0;
      st_um    <= 1'b0;
      st_im    <= '0;
      ca_bd    <= 1'b0;
      ca_exc   <= EXC_INT;
      ip_sw    <= '0;
      ip_hw    <= '0;
      epc      <= '0;
      badvaddr <= '0;
    end else begin
      ip_hw <= HardwareInt;
      if (wr) begin
        unique case (mem.MemWriteCPAddress)
          REG_STATUS: begin
            st_ie  <= wdata[ST_IE];
            st_exl <= wdata[ST_EXL];
            st_um  <= wdata[ST_UM];
            st_im  <= wdata[ST_IM +: 8];
          end
          REG_CAUSE: ip_sw <= wdata[CA_IP +: 2];
          REG_EPC:   epc   <= wdata;
          default: ;
        endcase
      end
      // nested exceptions keep the original EPC/BD
      if (ready && exc) begin
        if (!st_exl) begin
          epc   <= mem.MemIsInDelaySlot ? mem.MemPC - 32'd4
                                        : mem.MemPC;
          ca_bd <= mem.MemIsInDelaySlot;
        end
        ca_exc <= code;
        st_exl <= 1'b1;
        if (sets_badvaddr(code))
          badvaddr <= mem.MemBadAddress;
      end else if (ready && eret) begin
        st_exl <= 1'b0;
      end
    end
  end

  always_comb begin
    CPReadData = '0;
    unique case (CPReadAddress)
      REG_BADVADDR: CPReadData = badvaddr;
      REG_COUNT:    CPReadData = count;
      REG_COMPARE:  CPReadData = compare;
      REG_STATUS:   CPReadData = status_w;
      REG_CAUSE:    CPReadData = cause_w;
      REG_EPC:      CPReadData = epc;
      default: ;
    endcase
  end

endmodule
